// File: rtl/tmc4671_poller.sv
// tmc4671_poller: sequences TMC4671 SPI transactions for periodic position/velocity polling and buffered target-position writes.
module tmc4671_poller #(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int POLL_FREQ_HZ = 1_000,
  parameter logic [6:0] ADDR_TARGET = 7'h68,
  parameter logic [6:0] ADDR_POS = 7'h6B,
  parameter logic [6:0] ADDR_VEL = 7'h6A,
  parameter int START_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        target_valid,
  input  logic [31:0] target_data,
  output logic        target_ready,
  output logic        spi_transmit,
  output logic [6:0]  spi_address,
  output logic        spi_writeNOTread,
  output logic [31:0] spi_data_in,
  input  logic [31:0] spi_data_out,
  input  logic        spi_busy,
  output logic [31:0] position_actual,
  output logic [31:0] velocity_actual,
  output logic        sample_valid,
  output logic        overrun,
  output logic        error
);
  localparam logic [31:0] RELOAD = 32'(CLOCK_FREQ_HZ / POLL_FREQ_HZ - 1);
  localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, CAPTURE} state_t;
  state_t state;
  logic [31:0] tick_cnt, target_buf, shadow;
  logic [7:0] start_cnt;
  logic poll_pending, phase_vel, tick;
  assign tick = enable && tick_cnt == 32'd0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      tick_cnt <= RELOAD;
      target_buf <= '0;
      shadow <= '0;
      start_cnt <= '0;
      poll_pending <= 1'b0;
      phase_vel <= 1'b0;
      target_ready <= 1'b1;
      spi_transmit <= 1'b0;
      spi_address <= '0;
      spi_writeNOTread <= 1'b0;
      spi_data_in <= '0;
      position_actual <= '0;
      velocity_actual <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      error <= 1'b0;
    end else begin
      spi_transmit <= 1'b0;
      sample_valid <= 1'b0;
      if (!enable) begin
        tick_cnt <= RELOAD;
        poll_pending <= 1'b0;
      end else if (tick) begin
        tick_cnt <= RELOAD;
        poll_pending <= 1'b1;
        if (poll_pending) overrun <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt - 32'd1;
      end
      if (target_valid && target_ready) begin
        target_buf <= target_data;
        target_ready <= 1'b0;
      end
      // target_ready low means the buffer holds an unserviced write
      case (state)
        IDLE: begin
          if (!target_ready) begin
            spi_address <= ADDR_TARGET;
            spi_writeNOTread <= 1'b1;
            spi_data_in <= target_buf;
            spi_transmit <= 1'b1;
            state <= ISSUE;
          end else if (poll_pending) begin
            spi_address <= ADDR_POS;
            spi_writeNOTread <= 1'b0;
            spi_data_in <= '0;
            phase_vel <= 1'b0;
            spi_transmit <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          start_cnt <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (spi_busy) begin
            state <= WAIT_DONE;
          end else if (start_cnt == START_LAST) begin
            error <= 1'b1;
            state <= IDLE;
            if (spi_writeNOTread) target_ready <= 1'b1;
            else if (!tick) poll_pending <= 1'b0;
          end else begin
            start_cnt <= start_cnt + 8'd1;
          end
        end
        WAIT_DONE: if (!spi_busy) state <= CAPTURE;
        CAPTURE: begin
          if (spi_writeNOTread) begin
            target_ready <= 1'b1;
            state <= IDLE;
          end else if (!phase_vel) begin
            shadow <= spi_data_out;
            spi_address <= ADDR_VEL;
            phase_vel <= 1'b1;
            spi_transmit <= 1'b1;
            state <= ISSUE;
          end else begin
            position_actual <= shadow;
            velocity_actual <= spi_data_out;
            sample_valid <= 1'b1;
            if (!tick) poll_pending <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
